// File: rtl/hazard_control_unit.sv
// hazard_control_unit: freeze/flush generation for the ID/EX pipeline boundary.
// Tracks destination tags of instructions in the EX and MEM slots, stalls the
// ID instruction on read-after-write hazards and squashes wrong-path
// instructions for BRANCH_FLUSH_CYCLES cycles after a taken branch.
// Optional feature macro: FORWARDING_EN (load-use-only stalls plus registered
// forward selects). Without it, selSrc1/selSrc2 are tied to 2'b00.
module hazard_control_unit #(
  parameter int REG_ADDR_W          = 4,
  parameter int BRANCH_FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  usesSrc1,
  input  logic                  twoSrc,
  input  logic                  idWriteBackEnabled,
  input  logic                  idMemoryReadEnabled,
  input  logic [REG_ADDR_W-1:0] idDestination,
  input  logic                  branchTaken,
  output logic                  freeze,
  output logic                  ifIdFlush,
  output logic                  idExFlush,
  output logic [1:0]            selSrc1,
  output logic [1:0]            selSrc2
);

  // Counter reload: the branch cycle itself is the first flush cycle.
  localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

  // Scoreboard: ID/EX slot (ex_*) and EX/MEM slot (mem_*).
  logic                  ex_wb_reg,       ex_wb_next;
  logic                  ex_mem_read_reg, ex_mem_read_next;
  logic [REG_ADDR_W-1:0] ex_dest_reg,     ex_dest_next;
  logic                  mem_wb_reg;
  logic [REG_ADDR_W-1:0] mem_dest_reg;
  logic [2:0]            flush_cnt_reg,   flush_cnt_next;

  logic [1:0][REG_ADDR_W-1:0] src_idx;
  logic [1:0]                 src_used;
  logic [1:0]                 match_ex;
  logic [1:0]                 match_mem;
  logic                       hazard;
  logic                       flushing;
  logic                       issue;

  assign src_idx  = {src2, src1};
  assign src_used = {twoSrc, usesSrc1};

  // Per-operand tag comparison against both tracked slots.
  for (genvar gi = 0; gi < 2; gi++) begin : g_match
    assign match_ex[gi]  = src_used[gi] & ex_wb_reg  & (src_idx[gi] == ex_dest_reg);
    assign match_mem[gi] = src_used[gi] & mem_wb_reg & (src_idx[gi] == mem_dest_reg);
  end

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = ex_mem_read_reg & (|match_ex);
`else
  // Without forwarding any pending producer in EX or MEM blocks the reader.
  assign hazard = (|match_ex) | (|match_mem);
  logic unused_mem_read;
  assign unused_mem_read = ex_mem_read_reg;
`endif

  // Outputs are gated by reset so they drop immediately while rst is low.
  assign flushing  = rst & (branchTaken | (flush_cnt_reg != 3'd0));
  assign freeze    = rst & hazard & ~flushing;
  assign ifIdFlush = flushing;
  assign idExFlush = flushing;
  assign issue     = ~freeze & ~flushing;

  // Next-state for the ID/EX slot and the flush counter.
  always_comb begin
    ex_wb_next       = 1'b0;
    ex_mem_read_next = 1'b0;
    ex_dest_next     = ex_dest_reg;
    flush_cnt_next   = flush_cnt_reg;
    if (issue) begin
      ex_wb_next       = idWriteBackEnabled;
      ex_mem_read_next = idMemoryReadEnabled;
      ex_dest_next     = idDestination;
    end
    if (branchTaken)
      flush_cnt_next = FLUSH_RELOAD;
    else if (flush_cnt_reg != 3'd0)
      flush_cnt_next = flush_cnt_reg - 3'd1;
  end

  // Scoreboard and flush counter registers; EX always advances into MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_wb_reg       <= 1'b0;
      ex_mem_read_reg <= 1'b0;
      ex_dest_reg     <= '0;
      mem_wb_reg      <= 1'b0;
      mem_dest_reg    <= '0;
      flush_cnt_reg   <= 3'd0;
    end else begin
      ex_wb_reg       <= ex_wb_next;
      ex_mem_read_reg <= ex_mem_read_next;
      ex_dest_reg     <= ex_dest_next;
      mem_wb_reg      <= ex_wb_reg;
      mem_dest_reg    <= ex_dest_reg;
      flush_cnt_reg   <= flush_cnt_next;
    end
  end

`ifdef FORWARDING_EN
  logic [1:0][1:0] sel_reg, sel_next;

  // Forward select captured with the instruction so it stays aligned with ID/EX.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    always_comb begin
      sel_next[gi] = 2'b00;
      if (issue) begin
        if (match_ex[gi])
          sel_next[gi] = 2'b01;
        else if (match_mem[gi])
          sel_next[gi] = 2'b10;
      end
    end
  end

  // Forward select registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sel_reg <= '0;
    else
      sel_reg <= sel_next;
  end

  assign selSrc1 = sel_reg[0];
  assign selSrc2 = sel_reg[1];
`else
  assign selSrc1 = 2'b00;
  assign selSrc2 = 2'b00;
`endif

endmodule
